// File: rtl/arm_fmt_pkg.sv
// Shared definitions for the fetch/decode stage and the SignExtend unit.
// Holds the extension-format codes, the opcode prefixes used to classify an
// instruction word, and the fetch FSM state type.
package arm_fmt_pkg;

  // Extension format codes driven into SignExtend
  localparam logic [2:0] FmtI   = 3'b000;
  localparam logic [2:0] FmtD   = 3'b001;
  localparam logic [2:0] FmtB   = 3'b010;
  localparam logic [2:0] FmtCb  = 3'b011;
  localparam logic [2:0] FmtMov = 3'b100;

  // B-format, instr[31:26]
  localparam logic [5:0]  OpB      = 6'b000101;
  localparam logic [5:0]  OpBl     = 6'b100101;
  // CB-format, instr[31:24]
  localparam logic [7:0]  OpCbz    = 8'b10110100;
  localparam logic [7:0]  OpCbnz   = 8'b10110101;
  localparam logic [7:0]  OpBcond  = 8'b01010100;
  // D-format, instr[31:21]
  localparam logic [10:0] OpLdur   = 11'b11111000010;
  localparam logic [10:0] OpStur   = 11'b11111000000;
  // Wide-move, instr[31:23]
  localparam logic [8:0]  OpMovz   = 9'b110100101;
  // I-format, instr[31:22]
  localparam logic [9:0]  OpAddi   = 10'b1001000100;
  localparam logic [9:0]  OpSubi   = 10'b1101000100;
  localparam logic [9:0]  OpAddis  = 10'b1011000100;
  localparam logic [9:0]  OpSubis  = 10'b1111000100;
  localparam logic [9:0]  OpAndi   = 10'b1001001000;
  localparam logic [9:0]  OpOrri   = 10'b1011001000;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StHold
  } fetch_state_e;

endpackage

// File: rtl/instr_format_decode.sv
// Combinational immediate-format pre-decoder.
// Ports:
//   instr     in  32  instruction word
//   ext_ctrl  out 3   format code for SignExtend (FmtI when has_imm=0)
//   shamt     out 2   MOVZ hw field, zero for all other formats
//   has_imm   out 1   word carries an immediate SignExtend must process
module instr_format_decode
  import arm_fmt_pkg::*;
(
  input  logic [31:0] instr,
  output logic [2:0]  ext_ctrl,
  output logic [1:0]  shamt,
  output logic        has_imm
);

  // Checks are ordered; the first matching prefix decides the format
  always_comb begin
    ext_ctrl = FmtI;
    shamt    = 2'b00;
    has_imm  = 1'b0;
    if (instr[31:26] == OpB || instr[31:26] == OpBl) begin
      ext_ctrl = FmtB;
      has_imm  = 1'b1;
    end else if (instr[31:24] == OpCbz || instr[31:24] == OpCbnz ||
                 instr[31:24] == OpBcond) begin
      ext_ctrl = FmtCb;
      has_imm  = 1'b1;
    end else if (instr[31:21] == OpLdur || instr[31:21] == OpStur) begin
      ext_ctrl = FmtD;
      has_imm  = 1'b1;
    end else if (instr[31:23] == OpMovz) begin
      ext_ctrl = FmtMov;
      shamt    = instr[22:21];
      has_imm  = 1'b1;
    end else if (instr[31:22] == OpAddi  || instr[31:22] == OpSubi  ||
                 instr[31:22] == OpAddis || instr[31:22] == OpSubis ||
                 instr[31:22] == OpAndi  || instr[31:22] == OpOrri) begin
      ext_ctrl = FmtI;
      has_imm  = 1'b1;
    end
  end

endmodule

// File: rtl/instr_fetch_decode.sv
// Fetch stage: owns the PC, keeps one request outstanding to instruction
// memory, registers the returned word with its pre-decoded immediate format
// and offers it downstream over valid/ready. Branch redirects flush any
// in-flight fetch.
// Ports:
//   CLK, resetl                      clock, async active-low reset
//   imem_req_valid/ready, imem_addr  fetch request channel
//   imem_rsp_valid, imem_rsp_data    fetch response channel
//   out_valid/ready, out_instr, out_pc, out_ext_ctrl, out_shamt, out_has_imm
//                                    decoded instruction to decode/extend
//   redirect_valid, redirect_pc      taken-branch redirect from execute
module instr_fetch_decode
  import arm_fmt_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        CLK,
  input  logic        resetl,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [63:0] out_pc,
  output logic [2:0]  out_ext_ctrl,
  output logic [1:0]  out_shamt,
  output logic        out_has_imm,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc
);

  fetch_state_e state_q, state_d;
  logic [63:0]  pc_q, pc_d;
  logic         drop_q, drop_d;
  logic         out_valid_q, out_valid_d;
  logic [31:0]  out_instr_q;
  logic [63:0]  out_pc_q;
  logic [2:0]   out_ext_ctrl_q;
  logic [1:0]   out_shamt_q;
  logic         out_has_imm_q;

  logic         redirect;
  logic         req_fire;
  logic         rsp_take;
  logic         out_fire;
  logic [2:0]   dec_ext_ctrl;
  logic [1:0]   dec_shamt;
  logic         dec_has_imm;

  instr_format_decode u_decode (
    .instr    (imem_rsp_data),
    .ext_ctrl (dec_ext_ctrl),
    .shamt    (dec_shamt),
    .has_imm  (dec_has_imm)
  );

  // Redirects are ignored until the FSM has left reset idle
  assign redirect = redirect_valid && (state_q != StIdle);
  assign req_fire = imem_req_valid && imem_req_ready;
  assign rsp_take = (state_q == StWait) && imem_rsp_valid && !redirect;
  assign out_fire = out_valid_q && out_ready;

  // State register
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: state_d = StReq;
      StReq:  if (req_fire) state_d = StWait;
      StWait: if (imem_rsp_valid) state_d = StHold;
      StHold: if (out_ready) state_d = StReq;
      default: state_d = StIdle;
    endcase
    if (redirect) state_d = StReq;
  end

  // FSM outputs: no new request while a flushed response is still owed
  always_comb begin
    imem_req_valid = (state_q == StReq) && !drop_q;
  end

  // Datapath next-state
  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = redirect_pc;
    end else if (out_fire) begin
      pc_d = pc_q + 64'd4;
    end

    drop_d = drop_q;
    if (drop_q && imem_rsp_valid) drop_d = 1'b0;
    // A flushed request is still owed a response unless it arrives this cycle
    if (redirect && (((state_q == StWait) && !imem_rsp_valid) ||
                     ((state_q == StReq) && req_fire))) begin
      drop_d = 1'b1;
    end

    out_valid_d = out_valid_q;
    if (redirect) begin
      out_valid_d = 1'b0;
    end else if (rsp_take) begin
      out_valid_d = 1'b1;
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      pc_q        <= RESET_PC;
      drop_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      drop_q      <= drop_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      out_instr_q    <= 32'h0;
      out_pc_q       <= 64'h0;
      out_ext_ctrl_q <= FmtI;
      out_shamt_q    <= 2'b00;
      out_has_imm_q  <= 1'b0;
    end else if (rsp_take) begin
      out_instr_q    <= imem_rsp_data;
      out_pc_q       <= pc_q;
      out_ext_ctrl_q <= dec_ext_ctrl;
      out_shamt_q    <= dec_shamt;
      out_has_imm_q  <= dec_has_imm;
    end
  end

  assign imem_addr    = pc_q;
  assign out_valid    = out_valid_q;
  assign out_instr    = out_instr_q;
  assign out_pc       = out_pc_q;
  assign out_ext_ctrl = out_ext_ctrl_q;
  assign out_shamt    = out_shamt_q;
  assign out_has_imm  = out_has_imm_q;

endmodule

// File: tb/tb_instr_fetch_decode.sv
module tb_instr_fetch_decode;

  logic        CLK = 1'b0;
  logic        resetl;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic [2:0]  out_ext_ctrl;
  logic [1:0]  out_shamt;
  logic        out_has_imm;
  logic        redirect_valid;
  logic [63:0] redirect_pc;

  always #5 CLK = ~CLK;

  instr_fetch_decode #(.RESET_PC(64'h100)) dut (
    .CLK            (CLK),
    .resetl         (resetl),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_ext_ctrl   (out_ext_ctrl),
    .out_shamt      (out_shamt),
    .out_has_imm    (out_has_imm),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  typedef struct {
    logic [31:0] word;
    logic [2:0]  ctrl;
    logic [1:0]  shamt;
    logic        has;
  } vec_t;

  vec_t        vecs[10];
  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_pc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  // Reference classifier: compares the word's leading bits as plain numbers.
  // Returns {has_imm, ext_ctrl, shamt}.
  function automatic logic [5:0] ref_decode(input logic [31:0] w);
    int unsigned u;
    u = w;
    if ((u >> 26) == 5 || (u >> 26) == 37) return 6'b1_010_00;
    if ((u >> 24) == 180 || (u >> 24) == 181 || (u >> 24) == 84) return 6'b1_011_00;
    if ((u >> 21) == 1986 || (u >> 21) == 1984) return 6'b1_001_00;
    if ((u >> 23) == 421) return {4'b1_100, 2'((u >> 21) % 4)};
    if ((u >> 22) == 580 || (u >> 22) == 836 || (u >> 22) == 708 ||
        (u >> 22) == 964 || (u >> 22) == 584 || (u >> 22) == 712) return 6'b1_000_00;
    return 6'b0_000_00;
  endfunction

  function automatic logic [31:0] gen_word(input int cls);
    logic [31:0] r;
    logic [9:0]  iops[6];
    iops = '{10'd580, 10'd836, 10'd708, 10'd964, 10'd584, 10'd712};
    r = $urandom;
    case (cls)
      0: return {(r[31] ? 6'd37 : 6'd5), r[25:0]};
      1: return {(r[31] ? 8'd180 : 8'd181), r[23:0]};
      2: return {8'd84, r[23:0]};
      3: return {(r[31] ? 11'd1986 : 11'd1984), r[20:0]};
      4: return {9'd421, r[22:0]};
      5: return {iops[$urandom_range(0, 5)], r[21:0]};
      default: return r;
    endcase
  endfunction

  // Bounded wait (at negedges) for a fetch request.
  task automatic wait_req(output int waited);
    waited = 0;
    while (!imem_req_valid && waited < 50) begin
      @(negedge CLK);
      waited++;
    end
    checks++;
    if (!imem_req_valid) begin
      errors++;
      $display("FAIL req_timeout: got no request, want one within 50 cycles");
    end
  endtask

  // One full fetch: request handshake, response, downstream transfer.
  // exp_wait < 0 skips the request-latency check.
  task automatic do_fetch(input logic [31:0] word, input logic [2:0] e_ctrl,
                          input logic [1:0] e_sh, input logic e_has,
                          input int req_dly, input int rsp_dly, input int stall,
                          input logic redir, input logic [63:0] tgt, input int exp_wait);
    int waited;
    wait_req(waited);
    if (!imem_req_valid) return;
    if (exp_wait >= 0) chk("req_latency", 64'(waited), 64'(exp_wait));
    chk("req_addr", imem_addr, exp_pc);
    repeat (req_dly) begin
      @(negedge CLK);
      chk1("req_hold_valid", imem_req_valid, 1'b1);
      chk("req_hold_addr", imem_addr, exp_pc);
    end
    imem_req_ready = 1'b1;
    @(negedge CLK);
    imem_req_ready = 1'b0;
    repeat (rsp_dly) begin
      chk1("wait_no_valid", out_valid, 1'b0);
      @(negedge CLK);
    end
    chk1("wait_no_req", imem_req_valid, 1'b0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = word;
    @(negedge CLK);
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    for (int i = 0; i <= stall; i++) begin
      chk1("out_valid", out_valid, 1'b1);
      chk("out_instr", 64'(out_instr), 64'(word));
      chk("out_pc", out_pc, exp_pc);
      chk("out_ext_ctrl", 64'(out_ext_ctrl), 64'(e_ctrl));
      chk("out_shamt", 64'(out_shamt), 64'(e_sh));
      chk1("out_has_imm", out_has_imm, e_has);
      chk1("hold_no_req", imem_req_valid, 1'b0);
      chk("hold_pc", imem_addr, exp_pc);
      if (i < stall) @(negedge CLK);
    end
    out_ready      = 1'b1;
    redirect_valid = redir;
    redirect_pc    = tgt;
    @(negedge CLK);
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    chk1("out_valid_clear", out_valid, 1'b0);
    exp_pc = redir ? tgt : exp_pc + 64'd4;
  endtask

  initial begin
    int          w;
    logic [31:0] rw;
    logic [5:0]  e;
    logic        redir;
    logic [63:0] tgt;

    vecs[0] = '{32'h91002820, 3'b000, 2'd0, 1'b1};  // ADDI
    vecs[1] = '{32'hD2A00021, 3'b100, 2'd1, 1'b1};  // MOVZ hw=1
    vecs[2] = '{32'h14000010, 3'b010, 2'd0, 1'b1};  // B
    vecs[3] = '{32'hF8408020, 3'b001, 2'd0, 1'b1};  // LDUR
    vecs[4] = '{32'h8B020020, 3'b000, 2'd0, 1'b0};  // ADD
    vecs[5] = '{32'hB4000041, 3'b011, 2'd0, 1'b1};  // CBZ
    vecs[6] = '{32'h54000001, 3'b011, 2'd0, 1'b1};  // B.cond
    vecs[7] = '{32'hD2E00000, 3'b100, 2'd3, 1'b1};  // MOVZ hw=3
    vecs[8] = '{32'hF2800000, 3'b000, 2'd0, 1'b0};  // MOVK, not recognised
    vecs[9] = '{32'hB2000421, 3'b000, 2'd0, 1'b1};  // ORRI

    resetl         = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'h0;
    exp_pc         = 64'h100;

    repeat (2) @(negedge CLK);
    chk1("rst_req_valid", imem_req_valid, 1'b0);
    chk("rst_addr", imem_addr, 64'h100);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_instr", 64'(out_instr), 64'h0);
    chk("rst_out_pc", out_pc, 64'h0);
    chk("rst_ext_ctrl", 64'(out_ext_ctrl), 64'h0);
    chk("rst_shamt", 64'(out_shamt), 64'h0);
    chk1("rst_has_imm", out_has_imm, 1'b0);
    resetl = 1'b1;

    // Table vectors, zero-wait memory, downstream always ready
    for (int i = 0; i < 10; i++) begin
      do_fetch(vecs[i].word, vecs[i].ctrl, vecs[i].shamt, vecs[i].has,
               0, 0, 0, 1'b0, 64'h0, (i == 0) ? 1 : 0);
    end

    // Downstream stall for 5 cycles in HOLD
    do_fetch(32'h8B020020, 3'b000, 2'd0, 1'b0, 0, 0, 5, 1'b0, 64'h0, 0);

    // Redirect while in WAIT; response arrives 3 cycles later and is dropped
    wait_req(w);
    chk("wr_addr", imem_addr, exp_pc);
    imem_req_ready = 1'b1;
    @(negedge CLK);
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h2000;
    @(negedge CLK);
    redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk1("drop_no_req", imem_req_valid, 1'b0);
      chk1("drop_out_valid", out_valid, 1'b0);
      @(negedge CLK);
    end
    chk1("drop_no_req_rsp", imem_req_valid, 1'b0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h91002820;
    @(negedge CLK);
    imem_rsp_valid = 1'b0;
    chk1("drop_req_after", imem_req_valid, 1'b1);
    chk("drop_req_addr", imem_addr, 64'h2000);
    chk1("drop_out_valid_after", out_valid, 1'b0);
    exp_pc = 64'h2000;
    do_fetch(32'h14000010, 3'b010, 2'd0, 1'b1, 0, 1, 0, 1'b1, 64'h10, 0);

    // Redirect coinciding with the out handshake at pc=0x10
    do_fetch(32'hF8408020, 3'b001, 2'd0, 1'b1, 0, 0, 0, 1'b1, 64'h400, 0);
    do_fetch(32'h91002820, 3'b000, 2'd0, 1'b1, 0, 0, 0, 1'b0, 64'h0, 0);

    // Reset asserted during WAIT; late response ignored afterwards
    wait_req(w);
    imem_req_ready = 1'b1;
    @(negedge CLK);
    imem_req_ready = 1'b0;
    resetl = 1'b0;
    #1;
    chk1("midrst_req_valid", imem_req_valid, 1'b0);
    chk("midrst_addr", imem_addr, 64'h100);
    @(negedge CLK);
    resetl         = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hD2A00021;
    @(negedge CLK);
    imem_rsp_valid = 1'b0;
    chk1("postrst_out_valid", out_valid, 1'b0);
    chk1("postrst_req_valid", imem_req_valid, 1'b1);
    chk("postrst_addr", imem_addr, 64'h100);
    exp_pc = 64'h100;
    do_fetch(32'h54000001, 3'b011, 2'd0, 1'b1, 1, 0, 0, 1'b0, 64'h0, 0);

    // Randomised words, latencies, stalls and handshake redirects
    for (int n = 0; n < 40; n++) begin
      rw    = gen_word(int'($urandom_range(0, 6)));
      e     = ref_decode(rw);
      redir = ($urandom_range(0, 4) == 0);
      tgt   = {$urandom, $urandom} & ~64'h3;
      if (n == 20) begin
        redir = 1'b1;
        tgt   = 64'hFFFF_FFFF_FFFF_FFFC;  // next sequential pc wraps to 0
      end
      do_fetch(rw, e[4:2], e[1:0], e[5], int'($urandom_range(0, 2)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), redir, tgt, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, want finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instr_fetch_decode.md
# instr_fetch_decode

Fetch stage placed directly upstream of the sign-extension unit. Owns the 64-bit PC and issues one outstanding request at a time to instruction memory. Registers the returned 32-bit word, pre-decodes its immediate format, and presents the word plus the extension controls (instr[25:0], 3-bit format code, 2-bit shift amount) through a valid/ready handshake to decode/extend. Accepts branch redirects from execute, which flush any in-flight fetch.

## Interface
- RESET_PC, default 64'h0: PC value loaded on reset.
- CLK  in  1  clock; all state updates on rising edge.
- resetl  in  1  asynchronous, active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_addr  out  64  fetch address (current PC).
- imem_rsp_valid  in  1  response word valid.
- imem_rsp_data  in  32  returned instruction.
- out_valid  out  1  decoded instruction available.
- out_ready  in  1  downstream accepts.
- out_instr  out  32  full instruction word; the sign-extend unit takes [25:0].
- out_pc  out  64  PC of out_instr.
- out_ext_ctrl  out  3  format: I=000, D=001, B=010, CB=011, MOV=100.
- out_shamt  out  2  MOVZ hw field, instr[22:21]; 0 otherwise.
- out_has_imm  out  1  0 for R-format/unrecognised (ext_ctrl forced 000).
- redirect_valid  in  1  branch taken.
- redirect_pc  in  64  branch target.

## Operation
- FSM states: IDLE, REQ, WAIT, HOLD.
- IDLE: entered only from reset; moves to REQ on the first clock after resetl deasserts.
- REQ: imem_req_valid=1, imem_addr=pc. On imem_req_ready, go to WAIT.
- WAIT: on imem_rsp_valid, capture word/pc/decode into output regs, set out_valid, and go to HOLD.
- HOLD: out_valid=1. On out_ready, clear out_valid, pc <= pc+4 (64-bit wrap), and go to REQ.
- Decode priority, first match wins:
  - instr[31:26] ∈ {000101,100101} → B.
  - instr[31:24] ∈ {10110100,10110101,01010100} → CB.
  - instr[31:21] ∈ {11111000010,11111000000} → D.
  - instr[31:23] = 110100101 → MOV, with shamt=instr[22:21].
  - instr[31:22] ∈ {1001000100,1101000100,1011000100,1111000100,1001001000,1011001000} → I.
  - Otherwise has_imm=0.
- Redirect (highest priority, any non-IDLE state): pc <= redirect_pc; out_valid <= 0; go to REQ.
  - If it arrives in WAIT, set drop_pending. The next imem_rsp_valid is discarded and clears drop_pending; a new request is not issued until it clears.
  - If it arrives in REQ during a same-cycle imem_req_ready handshake, the accepted request is treated as in flight and drop_pending is set.
  - Redirect in the same cycle as an out_valid&out_ready handshake: the transfer completes, but the PC takes redirect_pc, not pc+4.
- imem_rsp_valid outside WAIT with drop_pending=0 is ignored.

## Timing
- Reset values: imem_req_valid=0, imem_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=0, out_ext_ctrl=000, out_shamt=0, out_has_imm=0, drop_pending=0, state IDLE.
- Reset mid-operation clears everything immediately; a late response is ignored.
- Response to out_valid: 1 cycle (registered).
- Peak throughput: one instruction per 3 cycles, with zero-wait memory and out_ready held high.
- Redirect to new imem_req_valid: next cycle, or one cycle after the dropped response arrives.
- Outputs are stable while out_valid=1 and out_ready=0.
- imem_addr is stable while imem_req_valid=1 and imem_req_ready=0, unless a redirect occurs.

## Structure
- Shared package `arm_fmt_pkg` holds:
  - Format code localparams (I, D, B, CB, MOV), used by both this block and SignExtend.
  - Opcode match constants.
  - State enum.
- Sub-module `instr_format_decode` (combinational): maps instr[31:0] to {ext_ctrl, shamt, has_imm}. It is unit-testable on its own.

## Test plan
- Reset with RESET_PC=64'h100, zero-wait memory returning 32'h91002820 (ADDI), out_ready=1 → first imem_addr=0x100; out_instr=91002820, ext_ctrl=000, has_imm=1; next imem_addr=0x104.
- Fetch word 32'hD2A00021 (MOVZ, hw=1) → ext_ctrl=100, shamt=01; word 32'h14000010 (B) → ext_ctrl=010; word 32'hF8408020 (LDUR) → ext_ctrl=001; word 32'h8B020020 (ADD) → has_imm=0, ext_ctrl=000.
- Hold out_ready=0 for 5 cycles in HOLD → outputs unchanged, no new request, pc unchanged.
- Redirect to 0x2000 while in WAIT, delayed response 3 cycles later → that response is dropped, and the next imem_addr=0x2000 is issued the cycle after the dropped response.
- Redirect to 0x400 in the same cycle as an out handshake at pc=0x10 → transfer completes and the next request address is 0x400, not 0x14.
- Assert resetl=0 during WAIT, then return a response after release → response ignored, out_valid stays 0, and first request is at RESET_PC.
